// File: rtl/sfft_peak_picker.sv
// rtl/sfft_peak_picker.sv - sweeps an SFFT spectrum and publishes the K largest-magnitude bins
// Optional feature macro: PEAK_SKIP_DC_EN (exclude bin 0 from the sweep)
module sfft_peak_picker #(
    parameter int FREQS  = 4,
    parameter int ADDR_W = 3,
    parameter int IN_W   = 32,
    parameter int AMPL_W = 24,
    parameter int K      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  OutputValid,
    input  logic [IN_W-1:0]       SFFT_OutReal,
    output logic [ADDR_W-1:0]     output_address,
    output logic [K*ADDR_W-1:0]   peak_bin,
    output logic [K*AMPL_W-1:0]   peak_ampl,
    output logic [3:0]            peak_count,
    output logic                  peaks_valid,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;

`ifdef PEAK_SKIP_DC_EN
    localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_BIN = '0;
`endif
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FREQS - 1);
    localparam logic [3:0]        K_CNT    = 4'(K);

    state_t              state, nextState;
    logic                ovQ, cmpEn, start, abort, doInsert;
    logic [ADDR_W-1:0]   binQ;
    logic [ADDR_W-1:0]   tblBin [K];
    logic [AMPL_W-1:0]   tblAmp [K];
    logic [3:0]          tblCnt;
    logic [ADDR_W-1:0]   nBin [K];
    logic [AMPL_W-1:0]   nAmp [K];
    logic [IN_W-1:0]     magFull;
    logic [AMPL_W-1:0]   newAmp;
    logic [K-1:0]        gt;

    // Unsigned negation makes the most-negative input land on 2^(IN_W-1), the largest magnitude.
    always_comb begin
        magFull = SFFT_OutReal[IN_W-1] ? -SFFT_OutReal : SFFT_OutReal;
        newAmp  = (|magFull[IN_W-1:AMPL_W]) ? '1 : magFull[AMPL_W-1:0];
    end

    assign start = OutputValid & ~ovQ;

    always_comb begin
        nextState = state;
        abort     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) nextState = CLEAR;
            CLEAR: nextState = SCAN;
            SCAN:  if (output_address == LAST_BIN) nextState = DRAIN;
            DRAIN: nextState = DONE;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if ((state == CLEAR || state == SCAN || state == DRAIN) && !OutputValid) begin
            abort     = 1'b1;
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Table is kept sorted descending, so gt is 0..0 1..1 and its first 1 is the insert point.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            gt[i]   = newAmp > tblAmp[i];
            nBin[i] = tblBin[i];
            nAmp[i] = tblAmp[i];
        end
        if (gt[0]) begin
            nBin[0] = binQ;
            nAmp[0] = newAmp;
        end
        for (int i = 1; i < K; i++) begin
            if (gt[i]) begin
                nBin[i] = gt[i-1] ? tblBin[i-1] : binQ;
                nAmp[i] = gt[i-1] ? tblAmp[i-1] : newAmp;
            end
        end
        doInsert = cmpEn && (state == SCAN || state == DRAIN) && (newAmp != '0) && gt[K-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovQ            <= 1'b0;
            cmpEn          <= 1'b0;
            binQ           <= '0;
            output_address <= '0;
            peak_bin       <= '0;
            peak_ampl      <= '0;
            peak_count     <= '0;
            peaks_valid    <= 1'b0;
            tblCnt         <= '0;
            for (int i = 0; i < K; i++) begin
                tblBin[i] <= '0;
                tblAmp[i] <= '0;
            end
        end else begin
            ovQ         <= OutputValid;
            cmpEn       <= (state == SCAN);
            binQ        <= output_address;
            peaks_valid <= 1'b0;
            if (doInsert) begin
                for (int i = 0; i < K; i++) begin
                    tblBin[i] <= nBin[i];
                    tblAmp[i] <= nAmp[i];
                end
                if (tblCnt != K_CNT) tblCnt <= tblCnt + 4'd1;
            end
            case (state)
                CLEAR: begin
                    output_address <= FIRST_BIN;
                    tblCnt         <= '0;
                    for (int i = 0; i < K; i++) begin
                        tblBin[i] <= '0;
                        tblAmp[i] <= '0;
                    end
                end
                SCAN: if (output_address != LAST_BIN) output_address <= output_address + 1'b1;
                DONE: begin
                    output_address <= '0;
                    peaks_valid    <= 1'b1;
                    peak_count     <= tblCnt;
                    for (int i = 0; i < K; i++) begin
                        peak_bin[i*ADDR_W +: ADDR_W]  <= tblBin[i];
                        peak_ampl[i*AMPL_W +: AMPL_W] <= tblAmp[i];
                    end
                end
                default: ;
            endcase
            if (abort) output_address <= '0;
        end
    end

endmodule

// File: tb/tb_sfft_peak_picker.sv
// tb/tb_sfft_peak_picker.sv - directed-vector bench for sfft_peak_picker
// Honours PEAK_SKIP_DC_EN when defined for the build.
module tb_sfft_peak_picker;
    localparam int FREQS  = 4;
    localparam int ADDR_W = 3;
    localparam int IN_W   = 32;
    localparam int AMPL_W = 24;
    localparam int K      = 6;
`ifdef PEAK_SKIP_DC_EN
    localparam int LAT   = FREQS + 2;
    localparam int FIRST = 1;
`else
    localparam int LAT   = FREQS + 3;
    localparam int FIRST = 0;
`endif

    logic                clk;
    logic                reset;
    logic                OutputValid;
    logic [IN_W-1:0]     SFFT_OutReal;
    logic [ADDR_W-1:0]   output_address;
    logic [K*ADDR_W-1:0] peak_bin;
    logic [K*AMPL_W-1:0] peak_ampl;
    logic [3:0]          peak_count;
    logic                peaks_valid;
    logic                busy;

    sfft_peak_picker #(.FREQS(FREQS), .ADDR_W(ADDR_W), .IN_W(IN_W), .AMPL_W(AMPL_W), .K(K)) dut (
        .clk(clk), .reset(reset), .OutputValid(OutputValid), .SFFT_OutReal(SFFT_OutReal),
        .output_address(output_address), .peak_bin(peak_bin), .peak_ampl(peak_ampl),
        .peak_count(peak_count), .peaks_valid(peaks_valid), .busy(busy)
    );

    logic [IN_W-1:0] mem [FREQS];
    int nChecks = 0;
    int nPass   = 0;
    int pulses  = 0;
    int eb [K];
    int ea [K];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spectrum source with one-cycle read latency
    always @(posedge clk) SFFT_OutReal <= mem[output_address];

    always @(negedge clk) if (peaks_valid) pulses++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkTable(input string tag, input int cnt);
        logic [K*ADDR_W-1:0] xb;
        logic [K*AMPL_W-1:0] xa;
        for (int i = 0; i < K; i++) begin
            xb[i*ADDR_W +: ADDR_W] = ADDR_W'(eb[i]);
            xa[i*AMPL_W +: AMPL_W] = AMPL_W'(ea[i]);
        end
        check({tag, " bins"}, peak_bin, xb);
        check({tag, " ampl"}, peak_ampl, xa);
        check({tag, " count"}, peak_count, cnt);
    endtask

    // Caller has OutputValid=1 set so the next posedge is the first edge that samples it
    task automatic runFrame(input string tag);
        int n;
        bit got;
        logic [ADDR_W-1:0] a1;
        @(posedge clk);
        n = 0; got = 0; a1 = '1;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) a1 = output_address;
            if (peaks_valid) got = 1;
        end
        check({tag, " latency"}, n, LAT);
        check({tag, " first addr"}, a1, FIRST);
        @(posedge clk);
        #1;
        check({tag, " pulse width"}, peaks_valid, 0);
        check({tag, " busy after"}, busy, 0);
    endtask

    task automatic startEdge();
        @(negedge clk) OutputValid = 1'b0;
        @(negedge clk) OutputValid = 1'b1;
    endtask

    task automatic setBasic();
        mem[0] = 32'd100; mem[1] = 32'hFFFF_FE0C; mem[2] = 32'd300; mem[3] = 32'd300;
`ifdef PEAK_SKIP_DC_EN
        eb = '{1, 2, 3, 0, 0, 0}; ea = '{500, 300, 300, 0, 0, 0};
`else
        eb = '{1, 2, 3, 0, 0, 0}; ea = '{500, 300, 300, 100, 0, 0};
`endif
    endtask

    task automatic setSat();
        mem[0] = 32'd5; mem[1] = 32'd5; mem[2] = 32'h7FFF_FFFF; mem[3] = 32'h8000_0000;
`ifdef PEAK_SKIP_DC_EN
        eb = '{2, 3, 1, 0, 0, 0}; ea = '{24'hFFFFFF, 24'hFFFFFF, 5, 0, 0, 0};
`else
        eb = '{2, 3, 0, 1, 0, 0}; ea = '{24'hFFFFFF, 24'hFFFFFF, 5, 5, 0, 0};
`endif
    endtask

    localparam int CNT = (FIRST == 1) ? 3 : 4;

    initial begin
        int p0;
        reset = 1'b0;
        OutputValid = 1'b0;
        setBasic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset bins", peak_bin, 0);
        check("reset ampl", peak_ampl, 0);
        check("reset count", peak_count, 0);
        check("reset valid", peaks_valid, 0);
        check("reset busy", busy, 0);
        check("reset addr", output_address, 0);

        OutputValid = 1'b1;
        @(negedge clk) reset = 1'b1;
        runFrame("basic");
        checkTable("basic", CNT);

        setSat();
        startEdge();
        runFrame("sat");
        checkTable("sat", CNT);

        setBasic();
        p0 = pulses;
        startEdge();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort busy before", busy, 1);
        OutputValid = 1'b0;
        @(negedge clk);
        check("abort busy after", busy, 0);
        repeat (10) @(negedge clk);
        check("abort no pulse", pulses, p0);
        setSat();
        checkTable("abort held", CNT);

        setBasic();
        OutputValid = 1'b1;
        runFrame("rerun");
        checkTable("rerun", CNT);

        startEdge();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset bins", peak_bin, 0);
        check("midreset ampl", peak_ampl, 0);
        check("midreset count", peak_count, 0);
        check("midreset busy", busy, 0);
        check("midreset addr", output_address, 0);
        @(negedge clk) reset = 1'b1;
        runFrame("postreset");
        checkTable("postreset", CNT);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
